// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done handshake bundle for serial_subtractor
//
// Purpose: groups the operand-start handshake, result-done handshake and
// status signals of the bit-serial subtractor.
// Ports (signals):
//    start_valid/start_ready : operand handshake (master drives valid)
//    a, b, borrow_in         : operands, sampled on start accept
//    diff, borrow_out        : result and final borrow
//    overflow                : two's-complement signed overflow
//    done_valid/done_ready   : result handshake (slave drives valid)
//    busy                    : operation in progress (RUN or DONE)

interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             borrow_in;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             overflow;
   logic             done_valid;
   logic             done_ready;
   logic             busy;

   modport master (
      output start_valid, a, b, borrow_in, done_ready,
      input  start_ready, diff, borrow_out, overflow, done_valid, busy
   );

   modport slave (
      input  start_valid, a, b, borrow_in, done_ready,
      output start_ready, diff, borrow_out, overflow, done_valid, busy
   );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - borrow_in, LSB first
//
// Purpose: one full-subtractor cell plus a borrow flop processes one bit per
// clock. Operands are taken on the start handshake, the result is offered on
// the done handshake and held until consumed.
// Ports:
//    clk   : clock, rising edge
//    rst_n : asynchronous active-low reset
//    bus   : serial_subtractor_if slave (handshakes, operands, results)

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_subtractor_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             br_q, br_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             d_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         res_q   <= res_d;
         br_q    <= br_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         cnt_q   <= cnt_d;
      end
   end

   // Full-subtractor cell on the current LSBs and running borrow.
   assign d_bit = sa_q[0] ^ sb_q[0] ^ br_q;

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      res_d   = res_q;
      br_d    = br_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.start_valid) begin
               sa_d    = bus.a;
               sb_d    = bus.b;
               br_d    = bus.borrow_in;
               a_msb_d = bus.a[WIDTH-1];
               b_msb_d = bus.b[WIDTH-1];
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // New bit enters at the MSB; after WIDTH shifts bit 0 sits at LSB.
            // The concat-then-shift form stays legal for WIDTH = 1.
            res_d = WIDTH'({d_bit, res_q} >> 1);
            br_d  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.done_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // All outputs come straight from registers; nothing combinational from inputs.
   assign bus.start_ready = (state_q == IDLE);
   assign bus.done_valid  = (state_q == DONE);
   assign bus.busy        = (state_q == RUN) || (state_q == DONE);
   assign bus.diff        = res_q;
   assign bus.borrow_out  = br_q;
   assign bus.overflow    = (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing `a - b - borrow_in` LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion to the combinational full adder in the adder-circuits set. It gives the arithmetic library a sequential, handshaked datapath block. Operands are accepted on a valid/ready start handshake, and the result is presented on a valid/ready done handshake.

## Interface
Parameters:
- `WIDTH`, default 8, operand/result width in bits; legal range is 1 or more.

Ports:
- `clk`, input, 1 bit, single clock; all state changes on the rising edge.
- `rst_n`, input, 1 bit, asynchronous active-low reset.
- `start_valid`, input, 1 bit, operands `a`, `b` and `borrow_in` are valid.
- `start_ready`, output, 1 bit, block is able to accept operands.
- `a`, input, `WIDTH` bits, minuend; sampled only on accept.
- `b`, input, `WIDTH` bits, subtrahend; sampled only on accept.
- `borrow_in`, input, 1 bit, initial borrow; sampled only on accept.
- `diff`, output, `WIDTH` bits, difference.
- `borrow_out`, output, 1 bit, final borrow (unsigned underflow).
- `overflow`, output, 1 bit, two's-complement signed overflow.
- `done_valid`, output, 1 bit, result outputs are valid.
- `done_ready`, input, 1 bit, consumer accepts the result.
- `busy`, output, 1 bit, high while in RUN or DONE.

## Operation
States:
- **IDLE**
  - `start_ready` = 1.
  - On `start_valid` && `start_ready`:
    - load shift registers `sa` ← `a` and `sb` ← `b`;
    - set borrow register `br` ← `borrow_in`;
    - latch `a[WIDTH-1]` and `b[WIDTH-1]`;
    - set bit counter ← 0;
    - go to RUN.
- **RUN**
  - Each cycle, with a0 = `sa[0]` and b0 = `sb[0]`:
    - d = a0 ^ b0 ^ `br`;
    - `br` ← (~a0 & b0) | (~(a0 ^ b0) & `br`);
    - d enters the result shift register at bit `WIDTH-1`, and the register shifts right;
    - `sa` and `sb` shift right;
    - counter increments.
  - When the counter reaches `WIDTH-1` (this is the last bit), go to DONE.
- **DONE**
  - `done_valid` = 1.
  - `diff` holds the assembled result.
  - `borrow_out` = final `br`.
  - `overflow` = (latched a msb ≠ latched b msb) && (`diff[WIDTH-1]` ≠ latched a msb).
  - On `done_valid` && `done_ready`, go to IDLE.

Rules:
- Arithmetic is modulo 2^WIDTH: `diff` = (`a` − `b` − `borrow_in`) mod 2^WIDTH.
- `borrow_out` = 1 iff `a` < `b` + `borrow_in` (unsigned).
- `start_ready` is 0 in RUN and DONE; `start_valid` is ignored there and no operands are captured.
- In DONE, `diff`, `borrow_out` and `overflow` are held stable until `done_ready` is sampled high. Back-pressure is unlimited.
- A result handshake and a new start cannot both be accepted in the same cycle. A new start is accepted no earlier than the cycle after the return to IDLE.
- `diff`, `borrow_out` and `overflow` keep their last value in IDLE. They are meaningful only while `done_valid` is high.
- For `WIDTH` = 1, RUN lasts exactly one cycle.

## Timing
- Reset values (asserted asynchronously, with `rst_n` low):
  - state = IDLE;
  - `start_ready` = 1, `done_valid` = 0, `busy` = 0;
  - `diff` = 0, `borrow_out` = 0, `overflow` = 0;
  - all internal registers = 0.
- Reset mid-RUN or mid-DONE aborts the operation; no partial result is presented. After `rst_n` rises, the first accept is possible on the first rising edge.
- Latency: operands are accepted on edge E0; bits are processed on edges E1..E`WIDTH`; `done_valid` goes high after edge E`WIDTH`, i.e. `WIDTH` cycles after accept.
- Throughput: one operation per `WIDTH` + 2 cycles when `done_ready` is held at 1.
- `start_ready`, `done_valid` and `busy` are decoded from registered state only; there are no combinational paths from inputs to outputs.

## Test plan
- **WIDTH=8, basic subtract:** `a`=0x35, `b`=0x12, `borrow_in`=0 → `diff`=0x23, `borrow_out`=0, `overflow`=0; `done_valid` rises exactly 8 cycles after accept.
- **WIDTH=8, unsigned underflow:** `a`=0x00, `b`=0x01 → `diff`=0xFF, `borrow_out`=1, `overflow`=0.
- **WIDTH=8, signed overflow and borrow-in:**
  - `a`=0x80, `b`=0x01 → `diff`=0x7F, `overflow`=1, `borrow_out`=0.
  - `a`=0x10, `b`=0x10, `borrow_in`=1 → `diff`=0xFF, `borrow_out`=1.
- **Back-pressure:** hold `done_ready`=0 for 5 cycles in DONE while pulsing `start_valid` → outputs stable, `start_ready`=0, no capture; after `done_ready`=1, the next start is accepted one cycle later.
- **Reset mid-RUN:** assert `rst_n`=0 at bit 3 of an operation → all outputs return to reset values immediately; after release, a fresh operation `a`=0x05, `b`=0x03 gives `diff`=0x02.
- **WIDTH=1, exhaustive:** run all 8 combinations of `a`, `b`, `borrow_in` → `diff` and `borrow_out` match the full-subtractor truth table; each result arrives 1 cycle after accept.
